// File: rtl/raster_pkg.sv
// Shared types and sizes for the raster front end: scanner states, coordinate widths, clamped box payload.
package raster_pkg;

    localparam int unsigned COORD_W        = 8;
    localparam int unsigned BOX_W          = 16;
    localparam int unsigned SCREEN_MAX_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
    } box_t;

endpackage

// File: rtl/bbox_clamp.sv
// Clamps raw 16-bit box coordinates to the screen and flags boxes that enclose no pixels.
module bbox_clamp
    import raster_pkg::*;
#(
    parameter int unsigned SCREEN_MAX = SCREEN_MAX_DEF
) (
    input  logic [BOX_W-1:0] x_min_i,
    input  logic [BOX_W-1:0] x_max_i,
    input  logic [BOX_W-1:0] y_min_i,
    input  logic [BOX_W-1:0] y_max_i,
    output box_t             box_c,
    output logic             empty_c
);

    function automatic logic [COORD_W-1:0] clamp(input logic [BOX_W-1:0] v);
        if (v > BOX_W'(SCREEN_MAX)) begin
            return COORD_W'(SCREEN_MAX);
        end
        return COORD_W'(v);
    endfunction

    always_comb begin
        box_c.x_min = clamp(x_min_i);
        box_c.x_max = clamp(x_max_i);
        box_c.y_min = clamp(y_min_i);
        box_c.y_max = clamp(y_max_i);
        empty_c     = (box_c.x_min > box_c.x_max) || (box_c.y_min > box_c.y_max);
    end

endmodule

// File: rtl/bbox_scanner.sv
// Walks every pixel of an accepted bounding box in row-major order over a valid/ready pixel stream.
module bbox_scanner
    import raster_pkg::*;
#(
    parameter int unsigned SCREEN_MAX = SCREEN_MAX_DEF,
    parameter int unsigned CNT_W      = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BOX_W-1:0]   bbox_x_min,
    input  logic [BOX_W-1:0]   bbox_x_max,
    input  logic [BOX_W-1:0]   bbox_y_min,
    input  logic [BOX_W-1:0]   bbox_y_max,
    input  logic               bbox_valid,
    output logic               bbox_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_last,
    output logic               done,
    output logic [CNT_W-1:0]   pix_count
);

    state_t state_q;
    box_t   box_q;
    box_t   clamp_box_c;
    logic   clamp_empty_c;

    logic               wrap_c;
    logic [COORD_W-1:0] next_x_c;
    logic [COORD_W-1:0] next_y_c;
    logic               next_last_c;
    logic               first_last_c;

    bbox_clamp #(
        .SCREEN_MAX(SCREEN_MAX)
    ) u_clamp (
        .x_min_i(bbox_x_min),
        .x_max_i(bbox_x_max),
        .y_min_i(bbox_y_min),
        .y_max_i(bbox_y_max),
        .box_c  (clamp_box_c),
        .empty_c(clamp_empty_c)
    );

    // Successor of the current pixel within the latched box.
    always_comb begin
        wrap_c       = (pix_x == box_q.x_max);
        next_x_c     = wrap_c ? box_q.x_min : pix_x + COORD_W'(1);
        next_y_c     = wrap_c ? pix_y + COORD_W'(1) : pix_y;
        next_last_c  = (next_x_c == box_q.x_max) && (next_y_c == box_q.y_max);
        first_last_c = (clamp_box_c.x_min == clamp_box_c.x_max) &&
                       (clamp_box_c.y_min == clamp_box_c.y_max);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            box_q      <= '0;
            bbox_ready <= 1'b1;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            done       <= 1'b0;
            pix_count  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (bbox_valid && bbox_ready) begin
                        box_q      <= clamp_box_c;
                        bbox_ready <= 1'b0;
                        pix_count  <= '0;
                        if (clamp_empty_c) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_q   <= SCAN;
                            pix_x     <= clamp_box_c.x_min;
                            pix_y     <= clamp_box_c.y_min;
                            pix_valid <= 1'b1;
                            pix_last  <= first_last_c;
                        end
                    end
                end
                SCAN: begin
                    if (pix_valid && pix_ready) begin
                        pix_count <= pix_count + CNT_W'(1);
                        if (pix_last) begin
                            state_q   <= DONE;
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            pix_x    <= next_x_c;
                            pix_y    <= next_y_c;
                            pix_last <= next_last_c;
                        end
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done       <= 1'b0;
                    bbox_ready <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    pix_valid  <= 1'b0;
                    pix_last   <= 1'b0;
                    done       <= 1'b0;
                    bbox_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_scanner.sv
// Scoreboard bench for bbox_scanner: expected pixels are queued at box submission and popped on each handshake.
module tb_bbox_scanner;

    localparam int unsigned CNT_W = 17;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       last;
    } pix_t;

    logic             clk;
    logic             rst;
    logic [15:0]      bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
    logic             bbox_valid;
    logic             bbox_ready;
    logic [7:0]       pix_x, pix_y;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_last;
    logic             done;
    logic [CNT_W-1:0] pix_count;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];

    bbox_scanner #(
        .SCREEN_MAX(255),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bbox_x_min(bbox_x_min),
        .bbox_x_max(bbox_x_max),
        .bbox_y_min(bbox_y_min),
        .bbox_y_max(bbox_y_max),
        .bbox_valid(bbox_valid),
        .bbox_ready(bbox_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .done      (done),
        .pix_count (pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampv(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Pushes the expected pixel sequence and returns the expected pixel total.
    function automatic int model_box(input int x0, input int x1, input int y0, input int y1);
        int cx0 = clampv(x0);
        int cx1 = clampv(x1);
        int cy0 = clampv(y0);
        int cy1 = clampv(y1);
        pix_t p;
        int n = 0;
        if (cx0 > cx1 || cy0 > cy1) return 0;
        for (int y = cy0; y <= cy1; y++) begin
            for (int x = cx0; x <= cx1; x++) begin
                p.x    = 8'(x);
                p.y    = 8'(y);
                p.last = (x == cx1) && (y == cy1);
                exp_q.push_back(p);
                n++;
            end
        end
        return n;
    endfunction

    // Submits one box and drains it through the scoreboard; stall=1 randomises pix_ready.
    task automatic run_box(input string name, input int x0, input int x1, input int y0, input int y1,
                           input bit stall);
        int   exp_n;
        int   got_n = 0;
        bit   seen_done = 0;
        bit   prev_stalled = 0;
        pix_t prev;
        pix_t obs;
        pix_t e;
        exp_q.delete();
        pix_ready = 1'b1;
        for (int i = 0; i < 20 && !bbox_ready; i++) @(negedge clk);
        checks++;
        if (bbox_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: bbox_ready=%b required 1", name, bbox_ready);
        end
        exp_n      = model_box(x0, x1, y0, y1);
        bbox_x_min = 16'(x0);
        bbox_x_max = 16'(x1);
        bbox_y_min = 16'(y0);
        bbox_y_max = 16'(y1);
        bbox_valid = 1'b1;
        @(negedge clk);
        // Keep offering a junk box while busy; it must be ignored.
        bbox_x_min = 16'd100;
        bbox_x_max = 16'd101;
        bbox_y_min = 16'd100;
        bbox_y_max = 16'd101;
        checks++;
        if (bbox_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_ready: bbox_ready=%b required 0", name, bbox_ready);
        end
        for (int c = 1; c <= 400; c++) begin
            obs.x    = pix_x;
            obs.y    = pix_y;
            obs.last = pix_last;
            if (prev_stalled) begin
                checks++;
                if (pix_valid !== 1'b1 || obs !== prev) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b x=%0d y=%0d last=%b required valid=1 x=%0d y=%0d last=%b",
                             name, pix_valid, obs.x, obs.y, obs.last, prev.x, prev.y, prev.last);
                end
            end
            if (done === 1'b1) begin
                bbox_valid = 1'b0;
                seen_done  = 1;
                checks++;
                if (pix_valid !== 1'b0 || exp_q.size() != 0 || got_n != exp_n) begin
                    errors++;
                    $display("FAIL %s done_state: pix_valid=%b left=%0d got=%0d required valid=0 left=0 got=%0d",
                             name, pix_valid, exp_q.size(), got_n, exp_n);
                end
                checks++;
                if (pix_count !== CNT_W'(exp_n)) begin
                    errors++;
                    $display("FAIL %s count: pix_count=%0d required %0d", name, pix_count, exp_n);
                end
                if (!stall) begin
                    checks++;
                    if (c != exp_n + 1) begin
                        errors++;
                        $display("FAIL %s latency: done at cycle %0d required %0d", name, c, exp_n + 1);
                    end
                end
                @(negedge clk);
                checks++;
                if (done !== 1'b0 || bbox_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s after_done: done=%b bbox_ready=%b required done=0 ready=1",
                             name, done, bbox_ready);
                end
                break;
            end
            pix_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_stalled = pix_valid && !pix_ready;
            prev = obs;
            if (pix_valid === 1'b1 && pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_pixel: x=%0d y=%0d required none", name, obs.x, obs.y);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL %s pixel%0d: x=%0d y=%0d last=%b required x=%0d y=%0d last=%b",
                                 name, got_n, obs.x, obs.y, obs.last, e.x, e.y, e.last);
                    end
                end
                got_n++;
            end
            @(negedge clk);
        end
        if (!seen_done) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: done never seen, required done within 400 cycles", name);
        end
        bbox_valid = 1'b0;
        pix_ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bbox_valid = 1'b0;
        pix_ready  = 1'b1;
        bbox_x_min = '0;
        bbox_x_max = '0;
        bbox_y_min = '0;
        bbox_y_max = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bbox_ready !== 1'b1 || pix_valid !== 1'b0 || pix_last !== 1'b0 || done !== 1'b0 ||
            pix_x !== 8'd0 || pix_y !== 8'd0 || pix_count !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b last=%b done=%b x=%0d y=%0d cnt=%0d required 1 0 0 0 0 0 0",
                     bbox_ready, pix_valid, pix_last, done, pix_x, pix_y, pix_count);
        end
    endtask

    task automatic test_basic();
        run_box("basic", 2, 4, 1, 2, 0);
    endtask

    task automatic test_single();
        run_box("single", 5, 5, 7, 7, 0);
    endtask

    task automatic test_empty();
        run_box("empty_x", 10, 3, 0, 0, 0);
        run_box("empty_y", 0, 0, 9, 8, 0);
    endtask

    task automatic test_clamp();
        run_box("clamp_x", 250, 300, 0, 0, 0);
        run_box("clamp_corner", 1000, 65535, 254, 400, 0);
    endtask

    task automatic test_stall();
        run_box("stall", 0, 3, 0, 3, 1);
    endtask

    task automatic test_back_to_back();
        run_box("b2b_a", 7, 9, 3, 3, 0);
        run_box("b2b_b", 0, 1, 0, 2, 1);
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        bbox_x_min = 16'd0;
        bbox_x_max = 16'd7;
        bbox_y_min = 16'd0;
        bbox_y_max = 16'd0;
        bbox_valid = 1'b1;
        pix_ready  = 1'b1;
        @(negedge clk);
        bbox_valid = 1'b0;
        for (int c = 0; c < 20 && hs < 3; c++) begin
            if (pix_valid === 1'b1) hs++;
            if (hs < 3) @(negedge clk);
        end
        checks++;
        if (pix_x !== 8'd2 || pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid third_pixel: x=%0d valid=%b required x=2 valid=1", pix_x, pix_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (pix_valid !== 1'b0 || bbox_ready !== 1'b1 || pix_count !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid state: valid=%b ready=%b cnt=%0d done=%b required 0 1 0 0",
                     pix_valid, bbox_ready, pix_count, done);
        end
        run_box("after_rst", 3, 4, 5, 6, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_empty();
        test_clamp();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bbox_scanner.md
BBOX_SCANNER -- requirements
Module: bbox_scanner

Interface
REQ-001 SHALL have parameter SCREEN_MAX, default 255, giving the largest legal pixel coordinate on either axis.
REQ-002 SHALL have parameter CNT_W, default 17, giving the width of the emitted-pixel counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port bbox_x_min, input, 16, integer bounding-box minimum x from the upstream bounding-box stage.
REQ-006 SHALL have port bbox_x_max, input, 16, integer bounding-box maximum x.
REQ-007 SHALL have port bbox_y_min, input, 16, integer bounding-box minimum y.
REQ-008 SHALL have port bbox_y_max, input, 16, integer bounding-box maximum y.
REQ-009 SHALL have port bbox_valid, input, 1, box fields are valid this cycle.
REQ-010 SHALL have port bbox_ready, output, 1, scanner accepts a box this cycle.
REQ-011 SHALL have port pix_x, output, 8, current pixel x.
REQ-012 SHALL have port pix_y, output, 8, current pixel y.
REQ-013 SHALL have port pix_valid, output, 1, pix_x/pix_y hold a pixel to emit.
REQ-014 SHALL have port pix_ready, input, 1, downstream consumes the pixel this cycle.
REQ-015 SHALL have port pix_last, output, 1, current pixel is the final pixel of the box.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when a box is finished.
REQ-017 SHALL have port pix_count, output, CNT_W, number of pixels emitted for the current or most recent box.

Function
REQ-018 SHALL use the states IDLE, SCAN and DONE.
REQ-019 SHALL assert bbox_ready only in IDLE; a box is accepted when bbox_valid and bbox_ready are both high.
REQ-020 SHALL clamp each accepted coordinate to SCREEN_MAX before use; inputs are treated as unsigned.
REQ-021 SHALL treat a box as empty when the clamped x_min > x_max or y_min > y_max.
REQ-022 An empty box SHALL go IDLE -> DONE with no pix_valid and pix_count = 0.
REQ-023 A non-empty box SHALL go IDLE -> SCAN, with pix_x = x_min, pix_y = y_min and pix_valid high in the cycle after acceptance.
REQ-024 SHALL scan row-major: x is the inner loop (x_min..x_max), y is the outer loop (y_min..y_max).
REQ-025 SHALL advance to the next pixel only on a cycle with pix_valid and pix_ready both high.
REQ-026 While pix_ready is low, pix_x, pix_y, pix_valid and pix_last SHALL hold their values.
REQ-027 At x = x_max, a handshake SHALL wrap x to x_min and increment y.
REQ-028 pix_last SHALL be high exactly when x = x_max and y = y_max while in SCAN.
REQ-029 A handshake with pix_last high SHALL move the state to DONE.
REQ-030 pix_count SHALL clear on box acceptance and increment on each pixel handshake.
REQ-031 pix_count SHALL equal (x_max-x_min+1)*(y_max-y_min+1) at done; its maximum is 65536.
REQ-032 DONE SHALL last exactly one cycle, assert done, deassert pix_valid, then return to IDLE.
REQ-033 Throughput SHALL be one pixel per cycle when pix_ready is held high.
REQ-034 Box inputs arriving while the scanner is not idle SHALL be ignored; the box is latched internally at acceptance.

Reset
REQ-035 On rst the state SHALL return to IDLE, including mid-scan, discarding the box in progress.
REQ-036 On rst, pix_x, pix_y and pix_count SHALL reset to 0; pix_valid, pix_last and done SHALL reset to 0; bbox_ready SHALL be 1 from the first cycle after reset.

Structure
REQ-037 Package raster_pkg SHALL hold state_t {IDLE, SCAN, DONE}, SCREEN_MAX_DEF = 255 and COORD_W = 8.
REQ-038 The clamp and empty check SHALL be the single combinational sub-module bbox_clamp; everything else SHALL be flat in bbox_scanner.

Verification
REQ-039 Box (2,4)x(1,2) with pix_ready=1 -> pixels (2,1)(3,1)(4,1)(2,2)(3,2)(4,2) on six consecutive cycles; pix_last on (4,2); done next cycle; pix_count = 6.
REQ-040 Box (5,5)x(7,7) -> single pixel (5,7) with pix_last=1; pix_count = 1.
REQ-041 Empty box x_min=10, x_max=3 -> no pix_valid; done pulses one cycle after acceptance; pix_count = 0.
REQ-042 Box (250,300)x(0,0) -> x clamped, pixels 250..255; pix_count = 6.
REQ-043 Random pix_ready stalls on box (0,3)x(0,3) -> outputs stable while stalled; 16 pixels, in order, none lost or duplicated.
REQ-044 rst asserted on the 3rd pixel of a scan -> IDLE, pix_valid = 0, bbox_ready = 1 next cycle; a new box then scans correctly.
